// File: rtl/mem_if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_if_pkg
// Description : Shared constants and request record for the 64-bit
//               single-cycle internal memory interface.
// Contents    : MEM_ADDR_W / MEM_DATA_W / MEM_BE_W widths, CMD_READ /
//               CMD_WRITE encodings, mem_req_t packed request record.
// Revision    : 1.0  initial release
// ============================================================================
package mem_if_pkg;

    localparam int MEM_ADDR_W = 18;
    localparam int MEM_DATA_W = 64;
    localparam int MEM_BE_W   = 8;

    localparam logic CMD_READ  = 1'b1;
    localparam logic CMD_WRITE = 1'b0;

    // Byte enables are active-low: a 0 bit writes that byte.
    typedef struct packed {
        logic                  cmd;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_BE_W-1:0]   be;
        logic [MEM_DATA_W-1:0] data;
    } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO, power-of-two depth, show-ahead output
//               (dout is the head entry whenever empty is low).
// Ports       : CLK, RESET (async, active-low)
//               push/din  - write when not full (a push while full is dropped,
//                           even if a pop happens in the same cycle)
//               pop/dout  - remove head when not empty
//               full, empty, count (occupancy, log2(Depth)+1 bits)
// Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic                     pop,
    input  logic [Width-1:0]         din,
    output logic [Width-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int AW = $clog2(Depth);
    localparam logic [AW-1:0] C_PTR_ONE = 1;
    localparam logic [AW:0]   C_CNT_ONE = 1;
    localparam logic [AW:0]   C_DEPTH   = Depth[AW:0];

    logic [Width-1:0] r_mem [Depth];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == C_DEPTH);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + C_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + C_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_initiator.sv
`default_nettype none
// ============================================================================
// Module      : mem_initiator
// Description : Requester port for the single-cycle internal memory bus.
//               Core requests are queued, issued strictly in order at up to
//               one per cycle, and read returns land in a response FIFO whose
//               free space is tracked by read credits.
// Ports       : CLK, RESET (async, active-low)
//               REQ_*  - core request valid/ready channel (cmd, addr,
//                        active-low BE, data, tag)
//               MEM_*  - memory strobe/command outputs, DRDY/DI/TI returns
//               RSP_*  - read response valid/ready channel (data, tag)
//               BUSY   - requests queued or reads not yet consumed
//               ERR    - sticky: DRDY seen with no read outstanding
// Revision    : 1.0  initial release
// ============================================================================
module mem_initiator
    import mem_if_pkg::*;
#(
    parameter int TagWidth = 21,
    parameter int ReqDepth = 4,
    parameter int RspDepth = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   REQ_VALID,
    output logic                   REQ_READY,
    input  logic                   REQ_CMD,
    input  logic [MEM_ADDR_W-1:0]  REQ_ADDR,
    input  logic [MEM_BE_W-1:0]    REQ_BE,
    input  logic [MEM_DATA_W-1:0]  REQ_DATA,
    input  logic [TagWidth-1:0]    REQ_TAG,
    output logic                   MEM_ACT,
    output logic                   MEM_CMD,
    output logic [MEM_ADDR_W-1:0]  MEM_ADDR,
    output logic [MEM_BE_W-1:0]    MEM_BE,
    output logic [MEM_DATA_W-1:0]  MEM_DO,
    output logic [TagWidth-1:0]    MEM_TO,
    input  logic                   MEM_DRDY,
    input  logic [MEM_DATA_W-1:0]  MEM_DI,
    input  logic [TagWidth-1:0]    MEM_TI,
    output logic                   RSP_VALID,
    input  logic                   RSP_READY,
    output logic [MEM_DATA_W-1:0]  RSP_DATA,
    output logic [TagWidth-1:0]    RSP_TAG,
    output logic                   BUSY,
    output logic                   ERR
);

    localparam int REQ_W = $bits(mem_req_t) + TagWidth;
    localparam int RSP_W = MEM_DATA_W + TagWidth;
    localparam int CW    = $clog2(RspDepth) + 1;
    localparam logic [CW-1:0] C_CRED_MAX = RspDepth[CW-1:0];
    localparam logic [CW-1:0] C_CRED_ONE = 1;
    localparam logic [1:0]    C_MASK_INIT = 2'd2;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    mem_req_t                      w_req_in;
    mem_req_t                      w_head;
    logic [TagWidth-1:0]           w_head_tag;
    logic [REQ_W-1:0]              w_req_din;
    logic [REQ_W-1:0]              w_req_dout;
    logic                          w_req_full;
    logic                          w_req_empty;
    logic [$clog2(ReqDepth):0]     w_req_count;
    logic                          w_req_push;
    logic                          w_issue;
    logic                          w_issue_rd;

    always_comb begin
        w_req_in.cmd  = REQ_CMD;
        w_req_in.addr = REQ_ADDR;
        w_req_in.be   = REQ_BE;
        w_req_in.data = REQ_DATA;
    end

    assign w_req_din              = {w_req_in, REQ_TAG};
    assign {w_head, w_head_tag}   = w_req_dout;
    assign REQ_READY              = ~w_req_full;
    assign w_req_push             = REQ_VALID & ~w_req_full;

    sync_fifo #(
        .Width (REQ_W),
        .Depth (ReqDepth)
    ) u_req_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (w_req_push),
        .pop   (w_issue),
        .din   (w_req_din),
        .dout  (w_req_dout),
        .full  (w_req_full),
        .empty (w_req_empty),
        .count (w_req_count)
    );

    // ------------------------------------------------------------------
    // Issue: head goes out if it is a write or a read with a free credit.
    // A blocked head stalls everything behind it (strict in-order).
    // ------------------------------------------------------------------
    logic [CW-1:0] r_credits;

    assign w_issue    = ~w_req_empty & ((w_head.cmd == CMD_WRITE) | (r_credits != '0));
    assign w_issue_rd = w_issue & (w_head.cmd == CMD_READ);

    logic                  r_mem_act;
    logic                  r_mem_cmd;
    logic [MEM_ADDR_W-1:0] r_mem_addr;
    logic [MEM_BE_W-1:0]   r_mem_be;
    logic [MEM_DATA_W-1:0] r_mem_do;
    logic [TagWidth-1:0]   r_mem_to;

    // Non-strobe fields hold their last value when nothing issues.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_mem_act  <= 1'b0;
            r_mem_cmd  <= CMD_WRITE;
            r_mem_addr <= '0;
            r_mem_be   <= '1;
            r_mem_do   <= '0;
            r_mem_to   <= '0;
        end else begin
            r_mem_act <= w_issue;
            if (w_issue) begin
                r_mem_cmd  <= w_head.cmd;
                r_mem_addr <= w_head.addr;
                r_mem_be   <= w_head.be;
                r_mem_do   <= w_head.data;
                r_mem_to   <= w_head_tag;
            end
        end
    end

    assign MEM_ACT  = r_mem_act;
    assign MEM_CMD  = r_mem_cmd;
    assign MEM_ADDR = r_mem_addr;
    assign MEM_BE   = r_mem_be;
    assign MEM_DO   = r_mem_do;
    assign MEM_TO   = r_mem_to;

    // ------------------------------------------------------------------
    // Return capture, startup mask, in-flight tracking, error flag
    // ------------------------------------------------------------------
    logic [1:0] r_mask;
    logic [1:0] r_inflight;
    logic       r_err;
    logic       w_mask_active;
    logic       w_capture;
    logic       w_spurious;
    logic       w_rsp_pop;
    logic       w_rsp_full;
    logic       w_rsp_empty;
    logic [$clog2(RspDepth):0] w_rsp_count;
    logic [RSP_W-1:0]          w_rsp_dout;

    // The mask swallows a return belonging to a read cut off by reset.
    assign w_mask_active = (r_mask != 2'd0);
    assign w_capture     = MEM_DRDY & ~w_mask_active & (r_inflight != 2'd0);
    assign w_spurious    = MEM_DRDY & ~w_mask_active & (r_inflight == 2'd0);
    assign w_rsp_pop     = ~w_rsp_empty & RSP_READY;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_mask     <= C_MASK_INIT;
            r_inflight <= 2'd0;
            r_err      <= 1'b0;
            r_credits  <= C_CRED_MAX;
        end else begin
            if (w_mask_active) begin
                r_mask <= r_mask - 2'd1;
            end
            if (w_spurious) begin
                r_err <= 1'b1;
            end
            case ({w_issue_rd, w_capture})
                2'b10:   r_inflight <= r_inflight + 2'd1;
                2'b01:   r_inflight <= r_inflight - 2'd1;
                default: r_inflight <= r_inflight;
            endcase
            // Credits mirror free response slots not yet promised to a read.
            case ({w_issue_rd, w_rsp_pop})
                2'b10:   r_credits <= r_credits - C_CRED_ONE;
                2'b01:   r_credits <= (r_credits == C_CRED_MAX) ? r_credits
                                                                : r_credits + C_CRED_ONE;
                default: r_credits <= r_credits;
            endcase
        end
    end

    sync_fifo #(
        .Width (RSP_W),
        .Depth (RspDepth)
    ) u_rsp_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (w_capture),
        .pop   (w_rsp_pop),
        .din   ({MEM_DI, MEM_TI}),
        .dout  (w_rsp_dout),
        .full  (w_rsp_full),
        .empty (w_rsp_empty),
        .count (w_rsp_count)
    );

    assign RSP_VALID           = ~w_rsp_empty;
    assign {RSP_DATA, RSP_TAG} = w_rsp_dout;
    assign BUSY                = ~w_req_empty | (r_credits != C_CRED_MAX);
    assign ERR                 = r_err;

    // Occupancy and response-full are informational only here.
    logic w_unused_ok;
    assign w_unused_ok = ^{w_req_count, w_rsp_count, w_rsp_full};

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_initiator
// Description : Scoreboard bench for mem_initiator. A shadow memory predicts
//               read data at request acceptance (valid because issue is in
//               order); a separate bus-side memory answers MEM_ACT reads one
//               cycle later. A monitor pops the expected queue on every
//               response handshake.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_initiator;

    localparam int TW = 21;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            REQ_VALID, REQ_CMD;
    logic [17:0]     REQ_ADDR;
    logic [7:0]      REQ_BE;
    logic [63:0]     REQ_DATA;
    logic [TW-1:0]   REQ_TAG;
    logic            REQ_READY;
    logic            MEM_ACT, MEM_CMD;
    logic [17:0]     MEM_ADDR;
    logic [7:0]      MEM_BE;
    logic [63:0]     MEM_DO;
    logic [TW-1:0]   MEM_TO;
    logic            MEM_DRDY;
    logic [63:0]     MEM_DI;
    logic [TW-1:0]   MEM_TI;
    logic            RSP_VALID, RSP_READY;
    logic [63:0]     RSP_DATA;
    logic [TW-1:0]   RSP_TAG;
    logic            BUSY, ERR;

    mem_initiator #(.TagWidth(TW), .ReqDepth(4), .RspDepth(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_CMD(REQ_CMD),
        .REQ_ADDR(REQ_ADDR), .REQ_BE(REQ_BE), .REQ_DATA(REQ_DATA), .REQ_TAG(REQ_TAG),
        .MEM_ACT(MEM_ACT), .MEM_CMD(MEM_CMD), .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE),
        .MEM_DO(MEM_DO), .MEM_TO(MEM_TO),
        .MEM_DRDY(MEM_DRDY), .MEM_DI(MEM_DI), .MEM_TI(MEM_TI),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_TAG(RSP_TAG),
        .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- bus-side memory responder ----------------
    logic [63:0]   bmem [logic [17:0]];
    logic          r_drdy = 1'b0;
    logic [63:0]   r_di   = '0;
    logic [TW-1:0] r_ti   = '0;
    logic          inj_drdy = 1'b0;
    logic [63:0]   inj_data = '0;
    logic [TW-1:0] inj_tag  = '0;

    always @(posedge CLK) begin : responder
        logic [63:0] w;
        w = bmem.exists(MEM_ADDR) ? bmem[MEM_ADDR] : 64'h0;
        r_drdy <= MEM_ACT && MEM_CMD;
        r_di   <= w;
        r_ti   <= MEM_TO;
        if (MEM_ACT && !MEM_CMD) begin
            for (int b = 0; b < 8; b++)
                if (!MEM_BE[b]) w[8*b +: 8] = MEM_DO[8*b +: 8];
            bmem[MEM_ADDR] = w;
        end
    end

    assign MEM_DRDY = r_drdy | inj_drdy;
    assign MEM_DI   = inj_drdy ? inj_data : r_di;
    assign MEM_TI   = inj_drdy ? inj_tag  : r_ti;

    // ---------------- reference model + scoreboard ----------------
    logic [63:0]   ref_mem [logic [17:0]];
    logic [84:0]   exp_q [$];
    logic [63:0]   last_data = '0;
    logic [TW-1:0] last_tag  = '0;
    int act_cnt = 0, act_rd = 0, run = 0, max_run = 0;

    task automatic model_accept(input bit cmd, input logic [17:0] a, input logic [7:0] be,
                                input logic [63:0] d, input logic [TW-1:0] tg);
        logic [63:0] cur;
        cur = ref_mem.exists(a) ? ref_mem[a] : 64'h0;
        if (cmd) begin
            exp_q.push_back({cur, tg});
        end else begin
            for (int b = 0; b < 8; b++)
                if (!be[b]) cur[8*b +: 8] = d[8*b +: 8];
            ref_mem[a] = cur;
        end
    endtask

    always @(negedge CLK) begin
        if (RESET === 1'b1) begin
            if (MEM_ACT) begin
                act_cnt++;
                if (MEM_CMD) act_rd++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (RSP_VALID && RSP_READY) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", {RSP_DATA, RSP_TAG}, 128'h0);
                    if ({RSP_DATA, RSP_TAG} == 85'h0) chk("unexpected_rsp_zero", 1, 0);
                end else begin
                    chk("rsp_data_tag", {RSP_DATA, RSP_TAG}, exp_q.pop_front());
                end
                last_data = RSP_DATA;
                last_tag  = RSP_TAG;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit rand_rdy = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
        if (rand_rdy) RSP_READY = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input bit cmd, input logic [17:0] a, input logic [7:0] be,
                        input logic [63:0] d, input logic [TW-1:0] tg);
        int n = 0;
        REQ_VALID = 1'b1; REQ_CMD = cmd; REQ_ADDR = a; REQ_BE = be;
        REQ_DATA = d; REQ_TAG = tg;
        while (!REQ_READY && n < 200) begin tick(); n++; end
        if (!REQ_READY) begin
            chk("req_ready_timeout", 0, 1);
        end else begin
            tick();
            model_accept(cmd, a, be, d, tg);
        end
        REQ_VALID = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (exp_q.size() > 0 && n < limit) begin tick(); n++; end
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        RESET = 1'b0; REQ_VALID = 0; REQ_CMD = 0; REQ_ADDR = '0; REQ_BE = '1;
        REQ_DATA = '0; REQ_TAG = '0; RSP_READY = 1'b0;
        repeat (3) tick();
        // Reset values
        chk("rst_mem_act", MEM_ACT, 0);
        chk("rst_mem_be", MEM_BE, 8'hFF);
        chk("rst_mem_addr_do_to", {MEM_ADDR, MEM_DO, MEM_TO}, 0);
        chk("rst_req_ready", REQ_READY, 1);
        chk("rst_rsp_valid", RSP_VALID, 0);
        chk("rst_busy_err", {BUSY, ERR}, 0);
        RESET = 1'b1;
        repeat (3) tick();

        // 1: full write then read, check 3-cycle latency
        RSP_READY = 1'b1;
        send(0, 18'h00010, 8'h00, 64'h1122334455667788, 21'h0);
        send(1, 18'h00010, 8'hFF, 64'h0, 21'h15);
        chk("lat_t0", RSP_VALID, 0);
        tick(); chk("lat_t1", RSP_VALID, 0);
        tick(); chk("lat_t2", RSP_VALID, 0);
        tick(); chk("lat_t3", RSP_VALID, 1);
        drain(20);
        chk("t1_data", last_data, 64'h1122334455667788);
        chk("t1_tag", last_tag, 21'h15);

        // 2: partial write over zero word
        send(0, 18'h00020, 8'h00, 64'h0, 21'h0);
        send(0, 18'h00020, 8'hF0, 64'hAAAA_AAAA_BBBB_BBBB, 21'h0);
        send(1, 18'h00020, 8'hFF, 64'h0, 21'h16);
        drain(20);
        chk("t2_data", last_data, 64'h00000000BBBBBBBB);

        // 3: stalled consumer, credit limit, request FIFO fill
        RSP_READY = 1'b0;
        a0 = act_rd;
        for (int t = 1; t <= 6; t++) send(1, 18'h00010, 8'hFF, 64'h0, 21'(t));
        repeat (8) tick();
        chk("stall_act_reads", act_rd - a0, 4);
        chk("stall_req_ready", REQ_READY, 1);
        chk("stall_rsp_valid", RSP_VALID, 1);
        send(1, 18'h00020, 8'hFF, 64'h0, 21'd7);
        send(1, 18'h00010, 8'hFF, 64'h0, 21'd8);
        chk("stall_req_full", REQ_READY, 0);
        tick();
        chk("stall_act_reads2", act_rd - a0, 4);
        RSP_READY = 1'b1;
        drain(100);
        chk("stall_last_tag", last_tag, 21'd8);

        // 4: mixed R,W,R,W at one per cycle
        repeat (2) tick();
        max_run = 0;
        send(1, 18'h00010, 8'hFF, 64'h0, 21'h21);
        send(0, 18'h00030, 8'h0F, 64'hDEAD_BEEF_0123_4567, 21'h0);
        send(1, 18'h00020, 8'hFF, 64'h0, 21'h22);
        send(0, 18'h00031, 8'h00, 64'hCAFE_F00D_1234_5678, 21'h0);
        chk("mix_busy_high", BUSY, 1);
        drain(30);
        repeat (2) tick();
        chk("mix_act_run", max_run, 4);
        chk("mix_busy_low", BUSY, 0);

        // 5: spurious DRDY
        inj_data = 64'h5555_6666_7777_8888; inj_tag = 21'h1ABCD;
        inj_drdy = 1'b1; tick(); inj_drdy = 1'b0; tick();
        chk("err_set", ERR, 1);
        chk("err_no_rsp", RSP_VALID, 0);
        repeat (5) tick();
        chk("err_sticky", ERR, 1);

        // 6: reset while a read is on the bus, late DRDY masked
        send(1, 18'h00010, 8'hFF, 64'h0, 21'h33);
        tick();
        chk("rst_act_before", MEM_ACT, 1);
        RESET = 1'b0;
        exp_q.delete();
        #1 chk("rst_async_act", MEM_ACT, 0);
        tick(); tick();
        RESET = 1'b1;
        inj_data = 64'h0BAD_0BAD_0BAD_0BAD; inj_tag = 21'h33;
        inj_drdy = 1'b1; tick(); tick(); inj_drdy = 1'b0;
        tick();
        chk("mask_err", ERR, 0);
        chk("mask_rsp_valid", RSP_VALID, 0);
        chk("mask_busy", BUSY, 0);
        RSP_READY = 1'b0;
        a0 = act_rd;
        for (int t = 0; t < 5; t++) send(1, 18'h00020, 8'hFF, 64'h0, 21'(40 + t));
        repeat (6) tick();
        chk("post_rst_credits", act_rd - a0, 4);
        RSP_READY = 1'b1;
        drain(50);

        // 7: randomized traffic
        rand_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) tick();
            else send(1'($urandom_range(0, 1)), 18'h00200 | 18'($urandom_range(0, 15)),
                      8'($urandom), {$urandom, $urandom}, 21'($urandom));
        end
        rand_rdy = 0;
        RSP_READY = 1'b1;
        drain(200);
        repeat (3) tick();
        chk("rand_err", ERR, 0);
        chk("rand_busy", BUSY, 0);
        chk("rand_rsp_valid", RSP_VALID, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
